pipeline_step_controller: RTL and testbench

PIPELINE_STEP_CONTROLLER -- requirements
Module: pipeline_step_controller

---
 rtl/pipeline_step_controller_if.sv | 33 +++
 rtl/pipeline_step_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_step_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_step_controller_if.sv
// Pipeline step controller bus: run-control requests in, pipeline enable and status out.
//   i_start/i_mode  run request and its mode (0 continuous, 1 step)
//   i_step          single-cycle step request
//   i_halt          halt instruction seen by fetch
//   i_abort         immediate stop
//   o_valid         pipeline enable to every stage
//   o_busy/o_done   run in progress / run finished
//   o_cycle_count   enabled cycles since the last accepted start
//   o_state         raw state encoding
interface pipeline_step_controller_if #(
  parameter int unsigned NB_CYCLES = 32
) ();
  logic                 i_start;
  logic                 i_mode;
  logic                 i_step;
  logic                 i_halt;
  logic                 i_abort;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_done;
  logic [NB_CYCLES-1:0] o_cycle_count;
  logic [2:0]           o_state;

  modport master (
    output i_start, i_mode, i_step, i_halt, i_abort,
    input  o_valid, o_busy, o_done, o_cycle_count, o_state
  );

  modport slave (
    input  i_start, i_mode, i_step, i_halt, i_abort,
    output o_valid, o_busy, o_done, o_cycle_count, o_state
  );
endinterface

// File: rtl/pipeline_step_controller.sv
// Run/step controller for a pipelined core: gates the pipeline enable for
// continuous or single-step execution, drains the stages behind fetch after a
// halt, and counts enabled cycles.
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-low reset
//   bus      pipeline_step_controller_if.slave (requests in, enable/status out)
module pipeline_step_controller #(
  parameter int unsigned NB_CYCLES    = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic                       i_clock,
  input logic                       i_reset,
  pipeline_step_controller_if.slave bus
);

  localparam int unsigned DRAIN_W = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STEP_WAIT = 3'd2;
  localparam logic [2:0] S_STEP_EXEC = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [NB_CYCLES-1:0] count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, drain counter and cycle counter.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;

    // Every enabled cycle counts, including one that is being aborted.
    if (valid_q && (count_q != {NB_CYCLES{1'b1}})) begin
      count_d = count_q + NB_CYCLES'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = bus.i_mode ? S_STEP_WAIT : S_RUN;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      S_STEP_WAIT: begin
        if (bus.i_step) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_STEP_EXEC: begin
        if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      S_DRAIN: begin
        // drain_q counts remaining drain cycles including the current one.
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition.
    if (bus.i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Output decode of the next state so the status flops line up with state_q.
  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_RUN:       begin valid_d = 1'b1; busy_d = 1'b1; end
      S_STEP_WAIT: begin busy_d  = 1'b1; end
      S_STEP_EXEC: begin valid_d = 1'b1; busy_d = 1'b1; end
      S_DRAIN:     begin valid_d = 1'b1; busy_d = 1'b1; end
      S_DONE:      begin done_d  = 1'b1; end
      default:     begin valid_d = 1'b0; end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_cycle_count = count_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Testbench for pipeline_step_controller: scenario tasks queue stimulus with the
// expected post-edge outputs, then replay them and compare against the DUT.
// A second instance with NB_CYCLES=4 covers counter saturation.
module tb_pipeline_step_controller;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, SWAIT = 3'd2, SEXEC = 3'd3,
                         DRAIN = 3'd4, DONE = 3'd5;

  typedef struct {
    logic st, md, sp, ht, ab;
  } stim_t;

  typedef struct {
    logic        v, b, d;
    logic [2:0]  s;
    logic [31:0] c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stim_t sq[$];
  exp_t  sb[$];

  pipeline_step_controller_if #(.NB_CYCLES(32)) bus ();
  pipeline_step_controller_if #(.NB_CYCLES(4))  bus2 ();

  pipeline_step_controller #(.NB_CYCLES(32), .DRAIN_CYCLES(4)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  pipeline_step_controller #(.NB_CYCLES(4), .DRAIN_CYCLES(4)) dut_sat (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status outputs for a given state, straight from the state table.
  function automatic exp_t mk(input logic [2:0] s, input int c);
    exp_t r;
    r.s = s;
    r.c = 32'(c);
    r.v = (s == RUN) || (s == SEXEC) || (s == DRAIN);
    r.b = (s == RUN) || (s == SWAIT) || (s == SEXEC) || (s == DRAIN);
    r.d = (s == DONE);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, md, sp, ht, ab);
    bus.i_start = st;
    bus.i_mode  = md;
    bus.i_step  = sp;
    bus.i_halt  = ht;
    bus.i_abort = ab;
  endtask

  // Queue one cycle of stimulus and the outputs expected after the next edge.
  task automatic plan(input logic st, md, sp, ht, ab, input logic [2:0] s, input int c);
    stim_t x;
    x.st = st; x.md = md; x.sp = sp; x.ht = ht; x.ab = ab;
    sq.push_back(x);
    sb.push_back(mk(s, c));
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_state !== 3'd0 || bus.o_cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_hold got v=%b b=%b d=%b s=%0d c=%0d want all 0",
               bus.o_valid, bus.o_busy, bus.o_done, bus.o_state, bus.o_cycle_count);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    total++;
    if (bus.o_state !== IDLE || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ignores_start got s=%0d v=%b want s=0 v=0", bus.o_state, bus.o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.o_state !== IDLE || bus2.o_state !== IDLE) begin
      bad++;
      $display("FAIL reset_release got s=%0d s2=%0d want 0 0", bus.o_state, bus2.o_state);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic run_plan(input string name);
    stim_t x;
    exp_t  e;
    int    n;
    n = 0;
    while (sq.size() > 0) begin
      x = sq.pop_front();
      drive(x.st, x.md, x.sp, x.ht, x.ab);
      tick();
      e = sb.pop_front();
      total++;
      if (bus.o_valid !== e.v || bus.o_busy !== e.b || bus.o_done !== e.d ||
          bus.o_state !== e.s || bus.o_cycle_count !== e.c) begin
        bad++;
        $display("FAIL %s cyc=%0d got v=%b b=%b d=%b s=%0d c=%0d want v=%b b=%b d=%b s=%0d c=%0d",
                 name, n, bus.o_valid, bus.o_busy, bus.o_done, bus.o_state, bus.o_cycle_count,
                 e.v, e.b, e.d, e.s, e.c);
      end
      n++;
    end
    drive(0, 0, 0, 0, 0);
  endtask

  // Start at cycle 0, halt at cycle 10: enabled 1..14, done from 15, count 14.
  task automatic test_continuous();
    for (int n = 1; n <= 17; n++) begin
      if (n <= 10)      plan(n == 1, 0, 0, 0, 0, RUN, n - 1);
      else if (n == 11) plan(0, 0, 0, 1, 0, DRAIN, n - 1);
      else if (n <= 14) plan(0, 0, 0, 0, 0, DRAIN, n - 1);
      else if (n == 15) plan(0, 0, 0, 0, 0, DONE, 14);
      else if (n == 16) plan(1, 0, 1, 0, 0, DONE, 14);
      else              plan(0, 0, 0, 0, 1, IDLE, 14);
    end
    run_plan("continuous");
  endtask

  // Three step pulses five cycles apart; a step during STEP_EXEC is dropped.
  task automatic test_step();
    plan(1, 1, 0, 0, 0, SWAIT, 0);
    for (int k = 1; k <= 3; k++) begin
      plan(0, 0, 1, 0, 0, SEXEC, k - 1);
      plan(0, 0, k == 2, 0, 0, SWAIT, k);
      plan(k == 3, 0, 0, 0, 0, SWAIT, k);
      plan(0, 0, 0, 0, 0, SWAIT, k);
      plan(0, 0, 0, 0, 0, SWAIT, k);
    end
    plan(0, 0, 0, 0, 1, IDLE, 3);
    run_plan("step");
  endtask

  task automatic test_halt_in_step();
    plan(1, 1, 0, 0, 0, SWAIT, 0);
    plan(0, 0, 0, 1, 0, SWAIT, 0);
    plan(0, 0, 1, 0, 0, SEXEC, 0);
    plan(0, 0, 1, 1, 0, DRAIN, 1);
    plan(0, 1, 0, 0, 0, DRAIN, 2);
    plan(0, 0, 1, 0, 0, DRAIN, 3);
    plan(0, 0, 0, 0, 0, DRAIN, 4);
    plan(0, 0, 0, 0, 0, DONE, 5);
    plan(1, 0, 1, 1, 0, DONE, 5);
    plan(0, 0, 0, 0, 1, IDLE, 5);
    run_plan("halt_in_step");
  endtask

  // Abort beats halt in RUN and beats drain completion; count is kept.
  task automatic test_abort();
    plan(1, 0, 0, 0, 0, RUN, 0);
    plan(0, 0, 1, 0, 0, RUN, 1);
    plan(1, 1, 0, 0, 0, RUN, 2);
    plan(0, 0, 0, 1, 1, IDLE, 3);
    plan(0, 0, 0, 1, 0, IDLE, 3);
    plan(1, 0, 0, 0, 0, RUN, 0);
    plan(0, 0, 0, 1, 0, DRAIN, 1);
    plan(0, 0, 0, 0, 0, DRAIN, 2);
    plan(0, 0, 0, 0, 0, DRAIN, 3);
    plan(0, 0, 0, 0, 0, DRAIN, 4);
    plan(0, 0, 0, 0, 1, IDLE, 5);
    plan(0, 0, 0, 0, 0, IDLE, 5);
    run_plan("abort");
  endtask

  task automatic test_reset_mid_drain();
    plan(1, 0, 0, 0, 0, RUN, 0);
    plan(0, 0, 0, 1, 0, DRAIN, 1);
    plan(0, 0, 0, 0, 0, DRAIN, 2);
    run_plan("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
        bus.o_state !== 3'd0 || bus.o_cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_drain got v=%b b=%b d=%b s=%0d c=%0d want all 0",
               bus.o_valid, bus.o_busy, bus.o_done, bus.o_state, bus.o_cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    plan(0, 0, 0, 0, 0, IDLE, 0);
    plan(1, 0, 0, 0, 0, RUN, 0);
    plan(0, 0, 0, 1, 0, DRAIN, 1);
    plan(0, 0, 0, 0, 0, DRAIN, 2);
    plan(0, 0, 0, 0, 0, DRAIN, 3);
    plan(0, 0, 0, 0, 0, DRAIN, 4);
    plan(0, 0, 0, 0, 0, DONE, 5);
    plan(0, 0, 0, 0, 1, IDLE, 5);
    run_plan("post_reset");
  endtask

  // 4-bit counter must stop at 15 over a 20-cycle run.
  task automatic test_saturation();
    exp_t e;
    for (int k = 0; k <= 21; k++) begin
      bus2.i_start = (k == 0);
      bus2.i_mode  = 1'b0;
      bus2.i_step  = 1'b0;
      bus2.i_halt  = 1'b0;
      bus2.i_abort = (k == 21);
      if (k == 21) sb.push_back(mk(IDLE, 15));
      else         sb.push_back(mk(RUN, (k < 15) ? k : 15));
      tick();
      e = sb.pop_front();
      total++;
      if (bus2.o_valid !== e.v || bus2.o_state !== e.s || bus2.o_cycle_count !== e.c[3:0]) begin
        bad++;
        $display("FAIL saturation cyc=%0d got v=%b s=%0d c=%0d want v=%b s=%0d c=%0d",
                 k, bus2.o_valid, bus2.o_state, bus2.o_cycle_count, e.v, e.s, e.c[3:0]);
      end
    end
    bus2.i_abort = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus2.i_start = 1'b0;
    bus2.i_mode  = 1'b0;
    bus2.i_step  = 1'b0;
    bus2.i_halt  = 1'b0;
    bus2.i_abort = 1'b0;
    test_reset();
    test_continuous();
    test_step();
    test_halt_in_step();
    test_abort();
    test_reset_mid_drain();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
